// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: command stage in front of the SR flip-flop bank.
// Raw request lines pass through a two-flop synchronizer and a debounce
// filter. A rising edge of the debounced level becomes a one-cycle S or R
// pulse, and S and R are never driven high together.
// Optional feature macro: SR_CMD_TOGGLE_EN adds a toggle request input
// (tog_req). A toggle issues S or R depending on the tracked output state.
module sr_cmd_gen #(
    parameter int DB_CYCLES  = 4,
    parameter int CNT_W      = 3,
    parameter int PRIORITY_R = 1
) (
    input  logic clk,
    input  logic CLRn,
    input  logic set_req,
    input  logic rst_req,
`ifdef SR_CMD_TOGGLE_EN
    input  logic tog_req,
`endif
    output logic S,
    output logic R,
    output logic q_track,
    output logic conflict
);

`ifdef SR_CMD_TOGGLE_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 2;
`endif

    // The counter reaches this value on the last stable cycle before the
    // debounced level is allowed to follow the synchronized input.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // Channel 0 is set, channel 1 is reset, and channel 2 is toggle when enabled.
    logic [NCH-1:0] raw;
    logic [NCH-1:0] rise;

`ifdef SR_CMD_TOGGLE_EN
    assign raw = {tog_req, rst_req, set_req};
`else
    assign raw = {rst_req, set_req};
`endif

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic             sync1_q;
        logic             sync2_q;
        logic             db_q;
        logic             db_d;
        logic             db_prev_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // Debounce: count consecutive cycles where the synchronized input
        // differs from the debounced level. Any agreement restarts the count.
        always_comb begin
            db_d  = db_q;
            cnt_d = cnt_q;
            if (sync2_q == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Synchronizer, debounce state, and a one-cycle-late copy of the
        // debounced level for rising-edge detection.
        always_ff @(posedge clk or negedge CLRn) begin
            if (!CLRn) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                db_q      <= 1'b0;
                db_prev_q <= 1'b0;
                cnt_q     <= '0;
            end else begin
                sync1_q   <= raw[gi];
                sync2_q   <= sync1_q;
                db_q      <= db_d;
                db_prev_q <= db_q;
                cnt_q     <= cnt_d;
            end
        end

        // A request qualifies only on a 0->1 transition of the debounced level.
        assign rise[gi] = db_q & ~db_prev_q;
    end

    logic s_q;
    logic s_d;
    logic r_q;
    logic r_d;
    logic q_track_q;
    logic q_track_d;
    logic conflict_q;
    logic conflict_d;
    logic set_hit;
    logic rst_hit;

    assign set_hit = rise[0];
    assign rst_hit = rise[1];

    // Arbitrate the qualified requests into at most one pulse. The tracked
    // state follows whichever pulse is issued.
    always_comb begin
        s_d        = 1'b0;
        r_d        = 1'b0;
        conflict_d = 1'b0;
        q_track_d  = q_track_q;

        if (set_hit && rst_hit) begin
            conflict_d = 1'b1;
            if (PRIORITY_R != 0) begin
                r_d = 1'b1;
            end else begin
                s_d = 1'b1;
            end
        end else if (set_hit) begin
            s_d = 1'b1;
        end else if (rst_hit) begin
            r_d = 1'b1;
        end

`ifdef SR_CMD_TOGGLE_EN
        // An explicit request overrides a toggle in the same cycle. In that
        // case the toggle is dropped and flagged as a conflict.
        if (rise[2]) begin
            if (set_hit || rst_hit) begin
                conflict_d = 1'b1;
            end else if (q_track_q) begin
                r_d = 1'b1;
            end else begin
                s_d = 1'b1;
            end
        end
`endif

        if (s_d) begin
            q_track_d = 1'b1;
        end else if (r_d) begin
            q_track_d = 1'b0;
        end
    end

    // Register the pulses so the outputs are stable well before the
    // downstream flip-flop samples them on the falling edge.
    always_ff @(posedge clk or negedge CLRn) begin
        if (!CLRn) begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            q_track_q  <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            r_q        <= r_d;
            q_track_q  <= q_track_d;
            conflict_q <= conflict_d;
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign q_track  = q_track_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Testbench for sr_cmd_gen. Two instances are built, one with reset
// priority and one with set priority, and both share the same stimulus.
// The reference model works from the behavioural rules. A raw sample reaches
// the filter two edges after it is taken. The debounced level flips once the
// last DB_CYCLES filter inputs all differ from it. A debounced rising edge
// produces a pulse on the following edge.
module tb_sr_cmd_gen;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic CLRn = 1'b0;
    logic set_req = 1'b0;
    logic rst_req = 1'b0;
`ifdef SR_CMD_TOGGLE_EN
    logic tog_req = 1'b0;
`endif
    logic s_p1, r_p1, q_p1, c_p1;
    logic s_p0, r_p0, q_p0, c_p0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sr_cmd_gen #(.DB_CYCLES(DB), .CNT_W(3), .PRIORITY_R(1)) u_p1 (
        .clk      (clk),
        .CLRn     (CLRn),
        .set_req  (set_req),
        .rst_req  (rst_req),
`ifdef SR_CMD_TOGGLE_EN
        .tog_req  (tog_req),
`endif
        .S        (s_p1),
        .R        (r_p1),
        .q_track  (q_p1),
        .conflict (c_p1)
    );

    sr_cmd_gen #(.DB_CYCLES(DB), .CNT_W(3), .PRIORITY_R(0)) u_p0 (
        .clk      (clk),
        .CLRn     (CLRn),
        .set_req  (set_req),
        .rst_req  (rst_req),
`ifdef SR_CMD_TOGGLE_EN
        .tog_req  (tog_req),
`endif
        .S        (s_p0),
        .R        (r_p0),
        .q_track  (q_p0),
        .conflict (c_p0)
    );

    // Reference model state. Channel 0 is set, 1 is reset, and 2 is toggle.
    // Model index p is the PRIORITY_R value of the instance.
    bit rawq  [3][$];
    bit syncq [3][$];
    bit m_db   [3];
    bit m_pend [3];
    bit m_s [2];
    bit m_r [2];
    bit m_c [2];
    bit m_q [2];

    task automatic model_reset();
        for (int ch = 0; ch < 3; ch++) begin
            rawq[ch].delete();
            syncq[ch].delete();
            m_db[ch]   = 1'b0;
            m_pend[ch] = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            m_s[p] = 1'b0;
            m_r[p] = 1'b0;
            m_c[p] = 1'b0;
            m_q[p] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit [2:0] raw);
        bit rs, rr, rt, sync, flip, all_diff;
        rs = m_pend[0];
        rr = m_pend[1];
        rt = m_pend[2];
        // Compute the outputs from requests that qualified on the previous edge.
        for (int p = 0; p < 2; p++) begin
            m_s[p] = 1'b0;
            m_r[p] = 1'b0;
            m_c[p] = 1'b0;
            if (rs && rr) begin
                m_c[p] = 1'b1;
                if (p == 1) m_r[p] = 1'b1;
                else        m_s[p] = 1'b1;
            end else if (rs) begin
                m_s[p] = 1'b1;
            end else if (rr) begin
                m_r[p] = 1'b1;
            end else if (rt) begin
                if (m_q[p]) m_r[p] = 1'b1;
                else        m_s[p] = 1'b1;
            end
            if (rt && (rs || rr)) m_c[p] = 1'b1;
            if (m_s[p]) m_q[p] = 1'b1;
            if (m_r[p]) m_q[p] = 1'b0;
        end
        // Update the debounced levels from the delayed raw history.
        for (int ch = 0; ch < 3; ch++) begin
            sync = (rawq[ch].size() >= 2) ? rawq[ch][rawq[ch].size() - 2] : 1'b0;
            rawq[ch].push_back(raw[ch]);
            if (rawq[ch].size() > 4) void'(rawq[ch].pop_front());
            syncq[ch].push_back(sync);
            if (syncq[ch].size() > DB) void'(syncq[ch].pop_front());
            all_diff = (syncq[ch].size() == DB);
            foreach (syncq[ch][k]) if (syncq[ch][k] == m_db[ch]) all_diff = 1'b0;
            flip = all_diff;
            m_pend[ch] = flip && !m_db[ch];
            if (flip) m_db[ch] = !m_db[ch];
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, " S_p1"},        s_p1, m_s[1]);
        check({ph, " R_p1"},        r_p1, m_r[1]);
        check({ph, " q_track_p1"},  q_p1, m_q[1]);
        check({ph, " conflict_p1"}, c_p1, m_c[1]);
        check({ph, " S_p0"},        s_p0, m_s[0]);
        check({ph, " R_p0"},        r_p0, m_r[0]);
        check({ph, " q_track_p0"},  q_p0, m_q[0]);
        check({ph, " conflict_p0"}, c_p0, m_c[0]);
        check({ph, " SR_excl_p1"},  s_p1 & r_p1, 1'b0);
        check({ph, " SR_excl_p0"},  s_p0 & r_p0, 1'b0);
    endtask

    // Drive one clock cycle of input, advance the model, then check at the
    // following falling edge.
    task automatic cyc(input string ph, input bit s, input bit r, input bit t);
        set_req = s;
        rst_req = r;
`ifdef SR_CMD_TOGGLE_EN
        tog_req = t;
`endif
        @(posedge clk);
`ifdef SR_CMD_TOGGLE_EN
        model_edge({t, r, s});
`else
        model_edge({1'b0, r, s});
`endif
        @(negedge clk);
        check_all(ph);
    endtask

    task automatic do_reset(input int n);
        CLRn = 1'b0;
        #1;
        model_reset();
        check_all("reset_async");
        repeat (n) @(posedge clk);
        @(negedge clk);
        check_all("reset_held");
        CLRn = 1'b1;
    endtask

    initial begin
        int dur;
        bit s, r, t;

        $display("step: power-on reset");
        do_reset(2);

        $display("step: set held, single S pulse expected");
        repeat (12) cyc("set_hold", 1'b1, 1'b0, 1'b0);
        repeat (8)  cyc("set_idle", 1'b0, 1'b0, 1'b0);

        $display("step: 3-cycle set glitch, no pulse expected");
        do_reset(1);
        repeat (3)  cyc("glitch", 1'b1, 1'b0, 1'b0);
        repeat (10) cyc("glitch_idle", 1'b0, 1'b0, 1'b0);

        $display("step: simultaneous set and reset");
        do_reset(1);
        repeat (10) cyc("both", 1'b1, 1'b1, 1'b0);
        repeat (8)  cyc("both_idle", 1'b0, 1'b0, 1'b0);

        $display("step: reset held 20 cycles, released, raised again");
        repeat (20)     cyc("rst_hold", 1'b0, 1'b1, 1'b0);
        repeat (DB + 2) cyc("rst_gap", 1'b0, 1'b0, 1'b0);
        repeat (10)     cyc("rst_again", 1'b0, 1'b1, 1'b0);
        repeat (8)      cyc("rst_idle", 1'b0, 1'b0, 1'b0);

        $display("step: CLRn pulsed mid-count with set held");
        do_reset(1);
        repeat (4)  cyc("pre_clr", 1'b1, 1'b0, 1'b0);
        do_reset(2);
        repeat (12) cyc("post_clr", 1'b1, 1'b0, 1'b0);
        repeat (8)  cyc("post_clr_idle", 1'b0, 1'b0, 1'b0);

`ifdef SR_CMD_TOGGLE_EN
        $display("step: three toggle presses");
        do_reset(1);
        for (int k = 0; k < 3; k++) begin
            repeat (8) cyc("tog_press", 1'b0, 1'b0, 1'b1);
            repeat (8) cyc("tog_idle", 1'b0, 1'b0, 1'b0);
        end
        $display("step: toggle with set on the same edge");
        repeat (8) cyc("tog_set", 1'b1, 1'b0, 1'b1);
        repeat (8) cyc("tog_set_idle", 1'b0, 1'b0, 1'b0);
`endif

        $display("step: randomized request segments");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset($urandom_range(1, 2));
            end
            s   = 1'($urandom_range(0, 1));
            r   = 1'($urandom_range(0, 1));
            t   = 1'($urandom_range(0, 1));
            dur = $urandom_range(1, 9);
            repeat (dur) cyc("random", s, r, t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_cmd_gen.md
Name: sr_cmd_gen

Overview:
- Upstream command stage for the SR flip-flop bank. Turns raw, bouncy set/reset request lines (push-buttons or switches) into clean, single-cycle S/R excitation pulses.
- Guarantees S and R are never high together, so the downstream flip-flop never enters its undefined S=R=1 case.
- Runs on the posedge of the shared clock. Outputs are therefore stable at the negedge where the downstream flip-flop samples.

Parameters:
- DB_CYCLES, 4: consecutive stable clock cycles a synchronized input must hold before its debounced level changes; legal range 1..2**CNT_W.
- CNT_W, 3: width of each debounce counter.
- PRIORITY_R, 1: simultaneous-request winner. 1 = reset wins, 0 = set wins.

Ports:
- clk  input  1  system clock; all state updates on its posedge.
- CLRn  input  1  asynchronous active-low reset.
- set_req  input  1  raw asynchronous set request.
- rst_req  input  1  raw asynchronous reset request.
- S  output  1  registered one-cycle set pulse to the SR flip-flop.
- R  output  1  registered one-cycle reset pulse to the SR flip-flop.
- q_track  output  1  shadow of the state the downstream flip-flop holds after the last issued pulse.
- conflict  output  1  one-cycle pulse when competing qualified requests occur in the same cycle.

Behaviour:
- Reset and interface:
  - One clock; reset is asynchronous and active-low (CLRn).
  - CLRn low immediately clears all synchronizer flops, debounced levels, counters, S, R, q_track and conflict to 0.
  - Registers are held at 0 while CLRn is low. First update is at the first posedge after CLRn rises.
- Synchronizer: each request passes through a 2-flop synchronizer; sync level = second flop.
- Debounce (per channel), evaluated at every posedge:
  - If sync == db: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: db <= sync, cnt <= 0.
  - Else: cnt <= cnt+1.
- Qualification: a request qualifies on a 0->1 transition of db. Falling db edges and a held-high db produce nothing. A new request requires db to return low first.
- Pulse generation (registered on the cycle after qualification):
  - Set only: S=1 for exactly one cycle; q_track <= 1.
  - Reset only: R=1 for exactly one cycle; q_track <= 0.
  - Both in the same cycle: only the PRIORITY_R winner pulses; conflict=1 for one cycle; q_track follows the winner.
  - Invariant: S and R are never 1 in the same cycle.
- Pulses are issued regardless of q_track; a redundant set is still emitted.
- Latency: number the first posedge that samples raw high as edge 1. db rises after edge 2+DB_CYCLES; S/R is high after edge 3+DB_CYCLES and low after edge 4+DB_CYCLES.
- Glitch rejection: a synchronized pulse shorter than DB_CYCLES cycles produces no pulse; the counter returns to 0.
- Reset mid-operation: any in-progress count or pending pulse is discarded. An input held high through reset release is re-synchronized and re-debounced from db=0, then produces exactly one pulse.

Optional Feature:
- Macro: SR_CMD_TOGGLE_EN.
- Defined:
  - Adds port tog_req (input, 1, raw toggle request), synchronized and debounced identically to the other channels.
  - A qualified toggle issues S if q_track=0, else R.
  - If a set or reset qualifies in the same cycle, the explicit request wins (PRIORITY_R between set/reset still applies), the toggle is dropped, and conflict=1.
- Undefined: tog_req port and its logic are absent; behaviour is as above.

Test Plan:
- Reset, then set_req held high from edge 1, DB_CYCLES=4 -> S=1 only in the cycle after edge 7, R=0 throughout, q_track=1 from edge 7 on, conflict=0.
- set_req raw high for 3 cycles then low, DB_CYCLES=4 -> no S pulse, q_track stays 0, debounce counter back to 0.
- set_req and rst_req raised on the same edge, PRIORITY_R=1 -> single R pulse, S never 1, conflict=1 for one cycle, q_track=0. Repeat with PRIORITY_R=0 -> single S pulse, q_track=1.
- rst_req held high 20 cycles -> exactly one R pulse. Release for ≥DB_CYCLES+2 cycles, then raise again -> second R pulse.
- set_req held high; CLRn pulsed low at edge 5 (mid-count) and released -> all outputs 0 during reset, one S pulse 3+DB_CYCLES edges after release.
- With SR_CMD_TOGGLE_EN: three separated tog_req presses from reset -> S, R, S pulses; q_track 1,0,1. tog_req with set_req on the same edge -> S only, conflict=1.
